playseq_sequenciador_preview: RTL and testbench

Preview sequencer for the PlaySeq game. It takes over the LED display and the sequence-memory read address to present stored entries 0..limite to the player. Each entry is lit for a fixed on-time and followed by a blank gap. The game control unit starts it with a pulse and receives a one-cycle completion pulse, replacing the open-coded mostra_leds/espera_led loop and its external LED timer.

---
 rtl/playseq_sequenciador_preview.sv | 92 +++++++++
 tb/tb_playseq_sequenciador_preview.sv | 136 +++++++++++++
 2 files changed

// File: rtl/playseq_sequenciador_preview.sv
// playseq_sequenciador_preview: shows stored entries 0..limite on the LEDs, each lit ON_CYCLES then blanked OFF_CYCLES.
module playseq_sequenciador_preview #(
    parameter int ADDR_W     = 4,
    parameter int DATA_W     = 4,
    parameter int ON_CYCLES  = 1000,
    parameter int OFF_CYCLES = 500
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              iniciar,
    input  logic              abortar,
    input  logic [ADDR_W-1:0] limite,
    input  logic [DATA_W-1:0] mem_dado,
    output logic [ADDR_W-1:0] mem_endereco,
    output logic [DATA_W-1:0] leds,
    output logic              ocupado,
    output logic              pronto,
    output logic [2:0]        db_estado
);
    localparam int MAXC = ON_CYCLES > OFF_CYCLES ? ON_CYCLES : OFF_CYCLES;
    localparam int TW   = MAXC > 1 ? $clog2(MAXC) : 1;
    localparam logic [TW-1:0] ON_LAST  = TW'(ON_CYCLES - 1);
    localparam logic [TW-1:0] OFF_LAST = TW'(OFF_CYCLES - 1);

    typedef enum logic [2:0] {
        OCIOSO  = 3'd0,
        BUSCA   = 3'd1,
        ACESO   = 3'd2,
        APAGADO = 3'd3,
        FIM     = 3'd4
    } estado_t;

    estado_t           r_estado;
    logic [ADDR_W-1:0] r_lim;
    logic [ADDR_W-1:0] r_end;
    logic [DATA_W-1:0] r_led;
    logic [TW-1:0]     r_timer;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_estado <= OCIOSO;
            r_lim    <= '0;
            r_end    <= '0;
            r_led    <= '0;
            r_timer  <= '0;
        end else if (r_estado != OCIOSO && abortar) begin
            r_estado <= OCIOSO;
            r_end    <= '0;
        end else begin
            case (r_estado)
                OCIOSO: begin
                    r_end <= '0;
                    if (iniciar && !abortar) begin
                        r_lim    <= limite;
                        r_estado <= BUSCA;
                    end
                end
                BUSCA: begin
                    r_led    <= mem_dado;
                    r_timer  <= '0;
                    r_estado <= ACESO;
                end
                ACESO: begin
                    r_timer  <= r_timer == ON_LAST ? '0 : r_timer + 1'b1;
                    r_estado <= r_timer == ON_LAST ? APAGADO : ACESO;
                end
                APAGADO: begin
                    r_timer <= r_timer == OFF_LAST ? '0 : r_timer + 1'b1;
                    // compare before incrementing so the last address never wraps
                    if (r_timer == OFF_LAST) begin
                        r_estado <= r_end == r_lim ? FIM : BUSCA;
                        r_end    <= r_end == r_lim ? r_end : r_end + 1'b1;
                    end
                end
                FIM: begin
                    r_end    <= '0;
                    r_estado <= OCIOSO;
                end
                default: begin
                    r_end    <= '0;
                    r_estado <= OCIOSO;
                end
            endcase
        end
    end

    assign mem_endereco = r_end;
    assign leds         = r_estado == ACESO ? r_led : '0;
    assign ocupado      = r_estado != OCIOSO;
    assign pronto       = r_estado == FIM;
    assign db_estado    = r_estado;
endmodule

// File: tb/tb_playseq_sequenciador_preview.sv
// tb_playseq_sequenciador_preview: randomized and directed checks against a cycle-indexed timeline model.
module tb_playseq_sequenciador_preview;
    localparam int AW = 4, DW = 4, ON = 3, OFF = 2, P = 1 + ON + OFF;

    logic          clock = 0, reset = 0, iniciar = 0, abortar = 0;
    logic [AW-1:0] limite = '0;
    logic [DW-1:0] mem_dado, leds;
    logic [AW-1:0] mem_endereco;
    logic          ocupado, pronto;
    logic [2:0]    db_estado;
    logic [DW-1:0] mem [16];
    int            total = 0, bad = 0;

    assign mem_dado = mem[mem_endereco];

    playseq_sequenciador_preview #(.ADDR_W(AW), .DATA_W(DW), .ON_CYCLES(ON), .OFF_CYCLES(OFF)) dut (
        .clock(clock), .reset(reset), .iniciar(iniciar), .abortar(abortar), .limite(limite),
        .mem_dado(mem_dado), .mem_endereco(mem_endereco), .leds(leds), .ocupado(ocupado),
        .pronto(pronto), .db_estado(db_estado)
    );

    always #5 clock = ~clock;

    // k counts cycles from the edge that sampled iniciar; each entry occupies P cycles
    function automatic void model(input int k, input int l, output logic [DW-1:0] e_leds,
                                  output logic e_oc, output logic e_pr,
                                  output logic [AW-1:0] e_addr, output logic [2:0] e_st);
        int n, j, r;
        n = (l + 1) * P;
        j = k / P;
        r = k % P;
        e_leds = '0; e_oc = 0; e_pr = 0; e_addr = '0; e_st = 3'd0;
        if (k < n) begin
            e_oc   = 1;
            e_addr = j[AW-1:0];
            e_st   = r == 0 ? 3'd1 : (r <= ON ? 3'd2 : 3'd3);
            e_leds = (r >= 1 && r <= ON) ? mem[j] : '0;
        end else if (k == n) begin
            e_oc = 1; e_pr = 1; e_addr = l[AW-1:0]; e_st = 3'd4;
        end
    endfunction

    task automatic run_preview(input string name, input int l, input bit disturb, input int stop_at);
        int n;
        logic [DW-1:0] el;
        logic [AW-1:0] ea;
        logic eo, ep;
        logic [2:0] es;
        n = (l + 1) * P;
        @(negedge clock); limite = l[AW-1:0]; iniciar = 1;
        @(negedge clock); iniciar = 0;
        for (int k = 0; k <= n + 2; k++) begin
            if (k > 0) @(negedge clock);
            model(k, l, el, eo, ep, ea, es);
            total++; if (leds !== el) begin bad++; $display("FAIL %s leds k=%0d got=%h exp=%h", name, k, leds, el); end
            total++; if (ocupado !== eo) begin bad++; $display("FAIL %s ocupado k=%0d got=%b exp=%b", name, k, ocupado, eo); end
            total++; if (pronto !== ep) begin bad++; $display("FAIL %s pronto k=%0d got=%b exp=%b", name, k, pronto, ep); end
            total++; if (mem_endereco !== ea) begin bad++; $display("FAIL %s addr k=%0d got=%0d exp=%0d", name, k, mem_endereco, ea); end
            total++; if (db_estado !== es) begin bad++; $display("FAIL %s estado k=%0d got=%0d exp=%0d", name, k, db_estado, es); end
            if (disturb) begin
                iniciar = (k == 3);
                if (k == 3) limite = 4'd5;
            end
            if (k == stop_at) break;
        end
        iniciar = 0;
    endtask

    task automatic check_zero(input string name);
        total++; if (leds !== '0) begin bad++; $display("FAIL %s leds got=%h exp=0", name, leds); end
        total++; if (ocupado !== 1'b0) begin bad++; $display("FAIL %s ocupado got=%b exp=0", name, ocupado); end
        total++; if (pronto !== 1'b0) begin bad++; $display("FAIL %s pronto got=%b exp=0", name, pronto); end
        total++; if (mem_endereco !== '0) begin bad++; $display("FAIL %s addr got=%0d exp=0", name, mem_endereco); end
        total++; if (db_estado !== 3'd0) begin bad++; $display("FAIL %s estado got=%0d exp=0", name, db_estado); end
    endtask

    task automatic test_reset;
        #1 check_zero("reset");
        @(negedge clock); reset = 1;
        @(negedge clock); check_zero("after_reset_release");
    endtask

    task automatic test_basic;          run_preview("basic_l2", 2, 0, -1);  endtask
    task automatic test_single;         run_preview("single_l0", 0, 0, -1); endtask
    task automatic test_full;           run_preview("full_l15", 15, 0, -1); endtask
    task automatic test_ignore_restart; run_preview("restart_ignored", 1, 1, -1); endtask

    task automatic test_abort;
        run_preview("abort_pre", 3, 0, P + 2);
        abortar = 1;
        @(negedge clock); abortar = 0;
        check_zero("abort");
        for (int i = 0; i < 4 * P; i++) begin
            @(negedge clock);
            total++; if (pronto !== 1'b0 || ocupado !== 1'b0) begin
                bad++; $display("FAIL abort_idle pronto/ocupado i=%0d got=%b%b exp=00", i, pronto, ocupado);
            end
        end
    endtask

    task automatic test_idle_abort;
        @(negedge clock); iniciar = 1; abortar = 1; limite = 4'd2;
        @(negedge clock); iniciar = 0; abortar = 0;
        check_zero("idle_abort_blocks_start");
    endtask

    task automatic test_reset_mid;
        run_preview("reset_mid_pre", 2, 0, 4);
        #2 reset = 0;
        #1 check_zero("reset_mid_async");
        @(negedge clock); reset = 1;
        run_preview("after_mid_reset", 0, 0, -1);
    endtask

    task automatic test_random;
        for (int t = 0; t < 5; t++) begin
            for (int i = 0; i < 16; i++) mem[i] = DW'(1 << $urandom_range(0, DW - 1));
            run_preview("random", int'($urandom_range(0, 5)), 0, -1);
        end
    endtask

    initial begin
        for (int i = 0; i < 16; i++) mem[i] = DW'(1 << (i % 4));
        test_reset;
        test_basic;
        test_single;
        test_full;
        test_abort;
        test_ignore_restart;
        test_idle_abort;
        test_reset_mid;
        test_random;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
